// File: rtl/prog_pkg.sv
// Shared program-path definitions for the loader and the fetch path.
package prog_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned NIB_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_DONE
  } ld_state_t;

endpackage

// File: rtl/loader_addr_ctr.sv
// Write-address and byte counter for the program loader.
// The address wraps modulo 2^ADDR_W through natural overflow.
module loader_addr_ctr #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] cnt
);

  // Load restarts the session, and enable advances by one written byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= '0;
    end else if (enable) begin
      addr <= addr + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: assembles nibble pairs into bytes and writes them to
// program memory at consecutive addresses.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running byte checksum).
module prog_loader
  import prog_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NIB_W  = NIB_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    count,
  input  logic                 in_valid,
  input  logic [NIB_W-1:0]     in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [2*NIB_W-1:0]   mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [2*NIB_W-1:0]   checksum
);

  ld_state_t          state;
  logic [NIB_W-1:0]   hi_nib;
  logic [ADDR_W-1:0]  count_q;
  logic [ADDR_W-1:0]  ctr_addr;
  logic [ADDR_W-1:0]  ctr_cnt;
  logic [ADDR_W-1:0]  cnt_next;
  logic               ctr_load;
  logic               ctr_en;
  logic               last_byte;

  // Counter controls, and the end-of-session test on the post-increment count.
  always_comb begin
    ctr_load  = (state == ST_IDLE) && start;
    ctr_en    = (state == ST_WRITE);
    cnt_next  = ctr_cnt + 1'b1;
    last_byte = (cnt_next == count_q);
  end

  loader_addr_ctr #(
    .ADDR_W(ADDR_W)
  ) u_addr_ctr (
    .clock     (clock),
    .reset     (reset),
    .load      (ctr_load),
    .load_addr (base_addr),
    .enable    (ctr_en),
    .addr      (ctr_addr),
    .cnt       (ctr_cnt)
  );

  // Session FSM with registered handshake, strobe and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi_nib    <= '0;
      count_q   <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_q <= count;
            busy    <= 1'b1;
            if (count != '0) begin
              state    <= ST_HI;
              in_ready <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (in_valid) begin
            hi_nib <= in_data;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          // Write strobe is presented during WRITE, so it is raised here.
          if (in_valid) begin
            mem_wdata <= {hi_nib, in_data};
            mem_addr  <= ctr_addr;
            mem_we    <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last_byte) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state    <= ST_HI;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [2*NIB_W-1:0] sum_q;

  // Running sum of written bytes, cleared when a session is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      sum_q <= '0;
    else if (ctr_load)
      sum_q <= '0;
    else if (state == ST_WRITE)
      sum_q <= sum_q + mem_wdata;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: driver issues sessions and queues
// expected writes/done events; a monitor compares them as they appear.
module tb_prog_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] count;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  prog_loader #(.ADDR_W(12), .NIB_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int          start_cyc;
    int          cnt;
    logic [7:0]  sum;
  } dn_t;

  wr_t        wq[$];
  dn_t        dq[$];
  logic [7:0] sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_we_cyc = -100;
  logic tog;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.addr));
          chk("write_data", 32'(mem_wdata), 32'(w.data));
        end
        last_we_cyc = cyc;
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          dn_t d;
          d = dq.pop_front();
          if (d.cnt == 0)
            chk("done_after_start", 32'(cyc - d.start_cyc), 32'd1);
          else
            chk("done_after_write", 32'(cyc - last_we_cyc), 32'd1);
          chk("checksum", 32'(checksum), 32'(d.sum));
        end
      end
    end
  end

  // Reference model: bytes land at consecutive addresses modulo 4096.
  task automatic model_session(input logic [11:0] base, input int n);
    logic [7:0]  sum;
    logic [11:0] a;
    dn_t d;
    sum = 8'h00;
    a = base;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = a;
      w.data = sb[i];
      wq.push_back(w);
      sum = sum + sb[i];
      a = a + 12'd1;
    end
    d.start_cyc = cyc;
    d.cnt = n;
`ifdef PROG_LOADER_CHECKSUM_EN
    d.sum = sum;
`else
    d.sum = 8'h00;
`endif
    dq.push_back(d);
  endtask

  // Present one nibble; mode 0 always valid, 1 toggling valid, 2 random valid.
  // Modes 1/2 also pulse start with junk parameters, which must be ignored.
  task automatic send_nib(input logic [3:0] n, input int mode);
    logic v;
    int guard;
    guard = 0;
    do begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin v = tog; tog = ~tog; end
      else v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? n : 4'($urandom);
      if (mode != 0) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = 12'($urandom);
        count     = 12'($urandom);
      end
      @(posedge clock);
      @(negedge clock);
      start    = 1'b0;
      in_valid = 1'b0;
      guard++;
    end while (!v && guard < 50);
    if (!v) chk("nibble_timeout", 32'd0, 32'd1);
  endtask

  // One complete session using bytes in sb; entered and left at a negedge.
  task automatic run_session(input logic [11:0] base, input int n, input int mode);
    int guard;
    start     = 1'b1;
    base_addr = base;
    count     = 12'(n);
    model_session(base, n);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    tog = 1'b0;
    if (n == 0) begin
      @(negedge clock);
      chk("busy_one_cycle", 32'(busy), 32'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = sb[i];
        send_nib(b[7:4], mode);
        send_nib(b[3:0], mode);
        chk("in_ready_write", 32'(in_ready), 32'd0);
        @(negedge clock);
      end
      guard = 0;
      while (busy && guard < 10) begin
        @(negedge clock);
        guard++;
      end
      chk("busy_end", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"},
        {20'(0), in_ready, mem_we, busy, done, checksum},
        32'd0);
    chk({tag, "_addr_data"}, {12'(0), mem_addr, mem_wdata}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    in_valid = 1'b0; in_data = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Two bytes back-to-back.
    sb = '{8'h1A, 8'h2B};
    run_session(12'h010, 2, 0);

    // Address wrap.
    sb = '{8'h34, 8'h56};
    run_session(12'hFFF, 2, 0);

    // Empty session.
    sb.delete();
    run_session(12'h123, 0, 0);

    // Toggling valid with ignored start pulses.
    sb = '{8'h7C};
    run_session(12'h055, 1, 1);

    // Reset after the high nibble of a byte.
    start = 1'b1; base_addr = 12'h200; count = 12'd1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    send_nib(4'h9, 0);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    sb = '{8'h01};
    run_session(12'h100, 1, 0);

    // Randomised sessions.
    for (int s = 0; s < 25; s++) begin
      int n;
      logic [11:0] base;
      n = $urandom_range(0, 4);
      base = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      sb.delete();
      for (int i = 0; i < n; i++) sb.push_back(8'($urandom));
      run_session(base, n, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    @(negedge clock);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("dones_drained", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, program memory address width.
REQ-002 SHALL have parameter NIB_W, default 4, nibble width; the memory word is 2*NIB_W bits.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a load session; sampled in IDLE only.
REQ-006 SHALL have port base_addr  input  ADDR_W  first write address, captured on accepted start.
REQ-007 SHALL have port count  input  ADDR_W  number of bytes to load, captured on accepted start; 0 means no writes.
REQ-008 SHALL have port in_valid  input  1  nibble source has data.
REQ-009 SHALL have port in_data  input  NIB_W  nibble; first nibble = instruction field (upper), second = operand field (lower).
REQ-010 SHALL have port in_ready  output  1  loader accepts a nibble this cycle.
REQ-011 SHALL have port mem_we  output  1  one-cycle program memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-013 SHALL have port mem_wdata  output  2*NIB_W  byte {instr, oprnd}.
REQ-014 SHALL have port busy  output  1  session in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at session end.
REQ-016 SHALL have port checksum  output  2*NIB_W  running byte sum (see Configuration).

Function
REQ-017 SHALL implement states IDLE, HI, LO, WRITE, DONE.
REQ-018 IDLE: start=1 captures base_addr/count, zeroes byte counter; next state HI if count!=0, else DONE.
REQ-019 A nibble is transferred only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in HI and LO.
REQ-020 HI: transfer stores nibble as upper half, next LO; LO: transfer stores lower half, next WRITE; no transfer = hold state.
REQ-021 WRITE: mem_we=1 for exactly one cycle with mem_addr = current address and mem_wdata = assembled byte; byte written one cycle after low-nibble transfer.
REQ-022 After WRITE, address SHALL increment modulo 2^ADDR_W (0xFFF wraps to 0x000) and byte counter increment; next DONE if counter equals count, else HI.
REQ-023 DONE: done=1 for one cycle, next IDLE.
REQ-024 busy SHALL be 1 in HI, LO, WRITE, DONE, and 0 in IDLE.
REQ-025 start asserted outside IDLE SHALL be ignored; captured base_addr/count unaffected.
REQ-026 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-027 reset SHALL force IDLE asynchronously; in_ready, mem_we, busy, done, mem_addr, mem_wdata, checksum all 0.
REQ-028 reset mid-session SHALL discard any partial byte and SHALL NOT produce a write or done pulse.

Configuration
REQ-029 With PROG_LOADER_CHECKSUM_EN defined, checksum SHALL clear on accepted start and add each written byte modulo 2^(2*NIB_W) in the WRITE cycle, holding after DONE.
REQ-030 Without PROG_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator logic SHALL exist.

Structure
REQ-031 State encoding typedef and ADDR_W/NIB_W defaults SHALL reside in shared package prog_pkg, also used by the fetch path.
REQ-032 Address/byte counter SHALL be sub-module loader_addr_ctr (load, enable, wrap); FSM and nibble assembly stay in prog_loader.

Verification
REQ-033 base_addr=0x010, count=2, nibbles 1,A,2,B back-to-back -> writes 0x1A@0x010, 0x2B@0x011, done one cycle after last write, checksum 0x45.
REQ-034 base_addr=0xFFF, count=2, nibbles 3,4,5,6 -> writes 0x34@0xFFF, 0x56@0x000.
REQ-035 count=0, start=1 -> no mem_we, done pulse the cycle after start, busy high exactly one cycle.
REQ-036 in_valid toggled 1/0 each cycle during count=1 load of 0x7C -> single write 0x7C, in_ready held while waiting, start pulses mid-session ignored.
REQ-037 reset asserted after high nibble 0x9 accepted -> all outputs 0 immediately; following session base 0x100 count 1 nibbles 0,1 writes 0x01@0x100.
REQ-038 Build without PROG_LOADER_CHECKSUM_EN, rerun REQ-033 -> identical writes, checksum 0 throughout.
